// File: rtl/bit_stream_pkg.sv
// Shared types and limits for the serial bit-stream transmitter.
package bit_stream_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} tx_state_t;

  localparam int MAX_GAP = 15;

endpackage

// File: rtl/bit_stream_tx_if.sv
// Load handshake and serial stream signals of bit_stream_tx.
interface bit_stream_tx_if #(
  parameter int WIDTH = 8
);
  logic             load_valid;
  logic [WIDTH-1:0] load_data;
  logic             load_ready;
  logic             serial_out;
  logic             serial_valid;
  logic             busy;
  logic             done;

  modport master (
    output load_valid, load_data,
    input  load_ready, serial_out, serial_valid, busy, done
  );

  modport slave (
    input  load_valid, load_data,
    output load_ready, serial_out, serial_valid, busy, done
  );
endinterface

// File: rtl/piso_shreg.sv
// Parallel-in/serial-out shift register, MSB first, zero fill on shift.
module piso_shreg #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             msb
);

  logic [WIDTH-1:0] shreg;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      shreg <= '0;
    end else if (load) begin
      shreg <= din;
    end else if (shift) begin
      shreg <= {shreg[WIDTH-2:0], 1'b0};
    end
  end

  assign msb = shreg[WIDTH-1];

endmodule

// File: rtl/bit_stream_tx.sv
// Serial frame transmitter: IDLE accept, SHIFT WIDTH bits MSB-first, GAP idle cycles.
module bit_stream_tx #(
  parameter int WIDTH = 8,
  parameter int GAP   = 2
) (
  input  logic            clock,
  input  logic            reset,
  bit_stream_tx_if.slave  bus
);
  import bit_stream_pkg::*;

  localparam int BW        = $clog2(WIDTH);
  localparam int GAP_EFF   = (GAP > MAX_GAP) ? MAX_GAP : GAP;
  localparam logic [3:0] GAP_RELOAD = 4'((GAP_EFF > 0) ? GAP_EFF - 1 : 0);

  tx_state_t     state, state_nxt;
  logic [BW-1:0] bit_cnt;
  logic [3:0]    gap_cnt;
  logic          msb;
  logic          accept;
  logic          last_bit;

  // The enum literal GAP is shadowed by the parameter, so states are package-qualified.
  assign accept   = (state == bit_stream_pkg::IDLE) && bus.load_valid;
  assign last_bit = (state == bit_stream_pkg::SHIFT) && (bit_cnt == '0);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= bit_stream_pkg::IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt        = state;
    bus.load_ready   = 1'b0;
    bus.serial_out   = 1'b0;
    bus.serial_valid = 1'b0;
    bus.busy         = 1'b0;
    unique case (state)
      bit_stream_pkg::IDLE: begin
        bus.load_ready = 1'b1;
        if (bus.load_valid) state_nxt = bit_stream_pkg::SHIFT;
      end
      bit_stream_pkg::SHIFT: begin
        bus.serial_out   = msb;
        bus.serial_valid = 1'b1;
        bus.busy         = 1'b1;
        if (bit_cnt == '0) begin
          state_nxt = (GAP_EFF > 0) ? bit_stream_pkg::GAP : bit_stream_pkg::IDLE;
        end
      end
      bit_stream_pkg::GAP: begin
        bus.busy = 1'b1;
        if (gap_cnt == '0) state_nxt = bit_stream_pkg::IDLE;
      end
      default: state_nxt = bit_stream_pkg::IDLE;
    endcase
  end

  // gap_cnt is loaded with GAP-1 so the GAP state lasts exactly GAP cycles.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bit_cnt  <= '0;
      gap_cnt  <= '0;
      bus.done <= 1'b0;
    end else begin
      bus.done <= last_bit;
      if (accept) begin
        bit_cnt <= BW'(WIDTH - 1);
      end else if ((state == bit_stream_pkg::SHIFT) && (bit_cnt != '0)) begin
        bit_cnt <= bit_cnt - 1'b1;
      end
      if (last_bit) begin
        gap_cnt <= GAP_RELOAD;
      end else if ((state == bit_stream_pkg::GAP) && (gap_cnt != '0)) begin
        gap_cnt <= gap_cnt - 1'b1;
      end
    end
  end

  piso_shreg #(.WIDTH(WIDTH)) u_shreg (
    .clock (clock),
    .reset (reset),
    .load  (accept),
    .shift (state == bit_stream_pkg::SHIFT),
    .din   (bus.load_data),
    .msb   (msb)
  );

endmodule

// File: doc/bit_stream_tx.md
# bit_stream_tx

Serial bit-stream transmitter that produces the 1-bit `In` stream consumed by the lab sequence-detector `FSM`. It accepts a parallel word over a valid/ready load handshake, shifts it out MSB-first one bit per clock with a qualifying valid strobe, and inserts a programmable idle gap between frames. It replaces hand-timed `#delay` stimulus with a synthesizable, cycle-exact source. Its `serial_out` connects directly to the detector's `In`.

## Interface
- `WIDTH`, 8: frame length in bits; legal range is 2 to 32.
- `GAP`, 2: idle cycles inserted after each frame; legal range is 0 to 15.

- `clock`  input  1  sole clock; all state changes on the rising edge.
- `reset`  input  1  asynchronous, active-low; 0 forces the reset state immediately.
- `load_valid`  input  1  `load_data` holds a frame to send.
- `load_data`  input  WIDTH  frame payload; bit `WIDTH-1` is transmitted first.
- `load_ready`  output  1  block can accept a frame this cycle.
- `serial_out`  output  1  current serial bit; drives the detector's `In`.
- `serial_valid`  output  1  `serial_out` carries a payload bit this cycle.
- `busy`  output  1  a frame is shifting or the gap is in progress.
- `done`  output  1  one-cycle pulse; the last bit of a frame has been sent.

## Operation
- The state machine has three states: IDLE, SHIFT and GAP.
- IDLE:
  - `load_ready`=1, `serial_out`=0, `serial_valid`=0, `busy`=0.
  - If `load_valid`=1 at a rising edge, the block captures `load_data` into the shift register, sets `bit_cnt`=WIDTH-1 and moves to SHIFT.
- SHIFT:
  - `serial_out`=`shreg[WIDTH-1]`, `serial_valid`=1, `busy`=1, `load_ready`=0.
  - Each edge shifts left by one with a 0 fill and decrements `bit_cnt`.
  - When `bit_cnt`=0, the next state is GAP if GAP>0, otherwise IDLE.
- GAP:
  - `serial_out`=0, `serial_valid`=0, `busy`=1, `load_ready`=0.
  - The block stays in GAP for exactly GAP cycles, counted by `gap_cnt`, then returns to IDLE.
- `done` is registered. It is 1 in the cycle immediately after the final SHIFT cycle, whether the block is then in GAP or in IDLE.
- `load_valid` and `load_data` are ignored outside IDLE. No frame is queued; the source must hold `load_valid` until it sees `load_ready`.
- Counter widths:
  - `bit_cnt` is `$clog2(WIDTH)` bits.
  - `gap_cnt` is 4 bits.
  - No wrap-around is reachable in legal operation.
- `serial_out`, `serial_valid`, `busy` and `load_ready` are decoded from registered state and the shift-register MSB only. They have no combinational path from the inputs.

## Timing
- Reset values: state=IDLE, shift register=0, both counters=0.
  - Outputs: `serial_out`=0, `serial_valid`=0, `busy`=0, `done`=0, `load_ready`=1.
- Latency: if a frame is accepted at edge k, its first bit is valid in the cycle after edge k. The last bit is valid after edge k+WIDTH-1, and `done`=1 after edge k+WIDTH.
- Frame period with `load_valid` held high continuously: WIDTH+GAP+1 cycles. This is WIDTH bits, GAP idle cycles and one IDLE accept cycle.
- Reset asserted mid-frame: the block enters IDLE asynchronously and the partial frame is discarded. `done` does not pulse, and `serial_out` drops to 0 without waiting for a clock.
- Reset released with `load_valid`=1: the earliest acceptance is the first rising edge at which `reset`=1.
- `load_valid` and the final SHIFT cycle coinciding: the frame is not accepted. `load_ready` is 0 in SHIFT.

## Structure
- Shared package `bit_stream_pkg` holds:
  - `typedef enum logic [1:0] {IDLE, SHIFT, GAP} tx_state_t`.
  - `localparam int MAX_GAP = 15`.
- One sub-module, `piso_shreg #(WIDTH)`, a parallel-in/serial-out shift register.
  - Inputs: `clock`, `reset`, `load`, `shift`, `din`.
  - Output: `msb`.
  - The top level contains only the FSM and the counters.

## Test plan
- Reset: hold `reset`=0 for 12 ns, then release.
  - During and after reset, outputs are 0 except `load_ready`=1.
  - `busy` stays 0 until the first accept.
- Single frame, `load_data`=8'b1011_0010:
  - After accept, `serial_out` is 1,0,1,1,0,0,1,0 on 8 consecutive cycles with `serial_valid`=1.
  - `done`=1 on cycle 9.
  - `serial_out`=0 during the 2 GAP cycles.
- Back-to-back, 8'hA5 then 8'h3C with `load_valid` held high:
  - The second frame's first bit appears exactly 11 cycles after the first frame's first bit.
  - `load_ready`=1 for exactly one cycle between the frames.
- Ignored load: change `load_data` to 8'hFF mid-SHIFT. The transmitted frame is unchanged and `load_ready` stays 0.
- Reset mid-frame: assert `reset` after 3 bits. `serial_out` and `serial_valid` go to 0 immediately and `done` never pulses.
- GAP=0, WIDTH=4:
  - Frame 4'b0110 gives bits 0,1,1,0 with `done` in the next cycle, and `load_ready`=1 in that same cycle.
  - Closed loop: wire `serial_out` into `FSM.In` and check that the detector output matches the golden sequence.
